axi4_timed_channel_pipe: RTL and testbench
==========================================

Name: axi4_timed_channel_pipe

Overview:
- Parametrised ready/valid delay pipe for one AXI4 channel (AR, AW, W, R or B).
- It generalises the fixed one-cycle record latching between the simulator-side channel records and the FPGATop channel ports. The latency is programmable at run time and applies per beat, the pipe has finite buffering, and backpressure is honoured in both directions.
- One instance is used per channel direction. Several instances together model host-link or DRAM latency in metasimulation without DPI-side bookkeeping.

Parameters:
- DATA_W, 64, width of the packed channel payload (for example a mem_rev_t slice). Must be ≥1.
- DEPTH, 8, number of buffered beats. Must be a power of two and ≥2.
- LAT_W, 8, width of the programmable extra latency.
- CNT_W, 32, width of the saturating stall counter.

Ports:
- clock, in, 1: sole clock. All state changes on posedge.
- reset, in, 1: asynchronous, active-high. Clears all state.
- flush, in, 1: synchronous discard of all buffered beats.
- lat_cfg, in, LAT_W: extra latency in cycles. Sampled per beat at enqueue.
- in_valid, in, 1: upstream beat valid.
- in_ready, out, 1: pipe can accept a beat.
- in_bits, in, DATA_W: upstream payload.
- out_valid, out, 1: head beat released.
- out_ready, in, 1: downstream accepts.
- out_bits, out, DATA_W: head payload.
- occupancy, out, log2(DEPTH)+1: number of buffered beats.
- stall_count, out, CNT_W: cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Storage is a circular buffer of DEPTH entries.
  - Each entry holds a payload and a remaining-delay counter rem[LAT_W].
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The occupancy counter is separate and runs 0..DEPTH.
- Enqueue happens on an edge where in_valid && in_ready.
  - mem[wptr] takes in_bits and rem[wptr] takes lat_cfg.
  - wptr increments.
- Delay countdown: every valid entry with rem≠0 decrements by 1 each cycle. rem saturates at 0 and never wraps.
- Release and dequeue:
  - out_valid = (occupancy≠0) && rem[rptr]==0 && !flush.
  - out_bits = mem[rptr]. This is combinational from the registered head. out_bits is don't-care when out_valid=0.
  - A beat dequeues on an edge where out_valid && out_ready, and rptr increments.
- Latency: a beat accepted at edge t is presented with out_valid=1 no earlier than cycle t+1+lat_cfg. With lat_cfg=0 the latency is exactly one cycle when downstream is ready.
- Ordering is strict FIFO. A later beat with smaller lat_cfg waits behind the head. Its own rem keeps counting down, so it releases immediately once it reaches the head, if already at 0.
- in_ready = (occupancy<DEPTH) && !flush. There is no full-with-simultaneous-dequeue bypass.
- Simultaneous enqueue and dequeue: occupancy is unchanged and both pointers advance. This is legal at any occupancy except full (no enqueue when full) and empty (no dequeue when empty).
- Changing lat_cfg affects only beats enqueued afterwards. Buffered beats keep their loaded rem.
- Flush:
  - On an edge with flush=1, occupancy, rptr and wptr go to 0 and every rem goes to 0.
  - No beat is accepted or released in that cycle, because in_ready=0 and out_valid=0.
  - stall_count is not cleared.
- stall_count increments on each edge where out_valid && !out_ready, and saturates at 2^CNT_W−1.
- Reset values: occupancy=0, pointers=0, all rem=0, stall_count=0, in_ready=1 (given flush=0), out_valid=0. Payload storage is not reset.
- Reset asserted mid-operation discards everything immediately and asynchronously. The first enqueue after deassertion behaves as it does from a fresh start.
- Handshake rules: upstream must hold in_bits stable while in_valid && !in_ready. The pipe holds out_valid and out_bits stable until dequeue, except on flush or reset.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

Test Plan:
- Latency sweep: lat_cfg=0, then 5, then 255, single beat 0xA5 with out_ready=1 → out_valid first seen at t+1, t+6, t+256 respectively; out_bits=0xA5.
- Fill/backpressure: DEPTH=8, lat_cfg=0, out_ready=0, stream 10 beats 1..10 → in_ready drops after the 8th accept and occupancy=8. Then out_ready=1 → beats 1..10 emerge in order, with in_ready high again after the first dequeue.
- Mixed latency ordering: beat A lat_cfg=10, beat B lat_cfg=0 on the next cycle → B is not released before A. B appears on the cycle immediately after A dequeues.
- Simultaneous enqueue and dequeue at occupancy 4, continuous streaming with lat_cfg=2 for 100 cycles → occupancy holds at 4 ± 0. Pointers wrap past 7 with no loss or duplication (checked by scoreboard).
- Flush with a beat arriving: occupancy 5, assert flush for one cycle while in_valid=1 → that beat is not accepted and occupancy=0 next cycle. A beat enqueued after the flush emerges first.
- Async reset mid-stream plus stall counter: 3 stall cycles give stall_count=3. Assert reset between clock edges → outputs go to reset values without a clock edge. stall_count saturation is checked with CNT_W=4: 20 stall cycles → 15.

Source files
------------

// File: rtl/axi4_timed_channel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : axi4_timed_channel_pipe
// Brief    : Ready/valid FIFO that holds each AXI4 channel beat for a
//            run-time programmable number of extra cycles before release.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_timed_channel_pipe #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int LAT_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [LAT_W-1:0]         lat_cfg,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_bits,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_bits,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         stall_count
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]    c_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [LAT_W-1:0]  r_rem [DEPTH];
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W:0]    r_occ;
    logic [CNT_W-1:0]  r_stall;

    logic              w_enq;
    logic              w_deq;
    logic [DEPTH-1:0]  w_live;

    assign in_ready    = (r_occ < c_DEPTH) && !flush;
    assign out_valid   = (r_occ != '0) && (r_rem[r_rptr] == '0) && !flush;
    assign out_bits    = r_mem[r_rptr];
    assign occupancy   = r_occ;
    assign stall_count = r_stall;

    assign w_enq = in_valid && in_ready;
    assign w_deq = out_valid && out_ready;

    // An entry is live when its distance from the read pointer is below occupancy.
    always_comb begin
        w_live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_live[i] = ({1'b0, PTR_W'(i) - r_rptr}) < r_occ;
        end
    end

    // Payload storage carries no reset; only the control state is cleared.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_mem[r_wptr] <= in_bits;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    r_rem[i] <= '0;
                end else if (w_enq && (r_wptr == PTR_W'(i))) begin
                    r_rem[i] <= lat_cfg;
                end else if (w_live[i] && (r_rem[i] != '0)) begin
                    r_rem[i] <= r_rem[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_occ  <= '0;
        end else if (flush) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Stall counter survives flush and saturates at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (out_valid && !out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_timed_channel_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_timed_channel_pipe
// Brief    : Directed self-checking bench for axi4_timed_channel_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_timed_channel_pipe;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [7:0]  lat_cfg;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_bits;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_bits;
    logic [3:0]  occupancy;
    logic [31:0] stall_count;

    logic        sat_flush;
    logic [3:0]  sat_lat_cfg;
    logic        sat_in_valid;
    logic        sat_in_ready;
    logic [7:0]  sat_in_bits;
    logic        sat_out_valid;
    logic        sat_out_ready;
    logic [7:0]  sat_out_bits;
    logic [1:0]  sat_occupancy;
    logic [3:0]  sat_stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    axi4_timed_channel_pipe #(
        .DATA_W(64), .DEPTH(8), .LAT_W(8), .CNT_W(32)
    ) u_dut (
        .clock(clock), .reset(reset), .flush(flush), .lat_cfg(lat_cfg),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .occupancy(occupancy), .stall_count(stall_count)
    );

    axi4_timed_channel_pipe #(
        .DATA_W(8), .DEPTH(2), .LAT_W(4), .CNT_W(4)
    ) u_sat (
        .clock(clock), .reset(reset), .flush(sat_flush), .lat_cfg(sat_lat_cfg),
        .in_valid(sat_in_valid), .in_ready(sat_in_ready), .in_bits(sat_in_bits),
        .out_valid(sat_out_valid), .out_ready(sat_out_ready), .out_bits(sat_out_bits),
        .occupancy(sat_occupancy), .stall_count(sat_stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lats [3] = '{0, 5, 255};
        int          n;
        int          exp_out;
        int          next_in;
        logic [63:0] d;
        logic [63:0] sb [$];

        reset = 1'b1; flush = 1'b0; lat_cfg = '0; in_valid = 1'b0; in_bits = '0; out_ready = 1'b0;
        sat_flush = 1'b0; sat_lat_cfg = '0; sat_in_valid = 1'b0; sat_in_bits = '0; sat_out_ready = 1'b0;

        tick();
        check("rst_occ",   occupancy,   0);
        check("rst_ready", in_ready,    1);
        check("rst_valid", out_valid,   0);
        check("rst_stall", stall_count, 0);
        #2 reset = 1'b0;
        tick();

        // Latency sweep with a single beat per setting
        for (int i = 0; i < 3; i++) begin
            lat_cfg = 8'(lats[i]); in_bits = 64'hA5; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check("lat_in_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 300) begin
                tick();
                n++;
            end
            check("lat_cycles", n, lats[i]);
            check("lat_bits", out_bits, 64'hA5);
            tick();
            check("lat_drain", occupancy, 0);
        end

        // Fill to full under backpressure, then drain in order
        lat_cfg = 8'd0; out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_bits = 64'(k);
            tick();
        end
        in_valid = 1'b1; in_bits = 64'd9;
        #1;
        check("fill_in_ready", in_ready,  0);
        check("fill_occ",      occupancy, 8);
        check("fill_head",     out_bits,  1);
        out_ready = 1'b1;
        tick();
        check("fill_ready_after_deq", in_ready,  1);
        check("fill_occ_after_deq",   occupancy, 7);
        exp_out = 2; next_in = 9; n = 0;
        while (exp_out <= 10 && n < 40) begin
            in_valid = (next_in <= 10); in_bits = 64'(next_in);
            #1;
            if (out_valid) begin
                check("fill_order", out_bits, 64'(exp_out));
                exp_out++;
            end
            if (in_valid && in_ready) next_in++;
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("fill_count", exp_out, 11);
        check("fill_empty", occupancy, 0);

        // Mixed latency: short-latency beat waits behind long-latency head
        lat_cfg = 8'd10; in_bits = 64'hAA; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        lat_cfg = 8'd0; in_bits = 64'hBB;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check("mix_wait", n, 9);
        check("mix_head", out_bits, 64'hAA);
        tick();
        check("mix_b_valid", out_valid, 1);
        check("mix_b_bits",  out_bits,  64'hBB);
        tick();
        check("mix_empty", occupancy, 0);

        // Continuous streaming at occupancy 4 with pointer wrap
        out_ready = 1'b0; lat_cfg = 8'd2; d = 64'h100;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_bits = d; sb.push_back(d); d++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("stream_pre_occ",   occupancy, 4);
        check("stream_pre_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1; in_bits = d;
            #1;
            check("stream_occ", occupancy, 4);
            if (out_valid && sb.size() > 0) check("stream_data", out_bits, sb.pop_front());
            else check("stream_valid", out_valid, 1);
            if (in_ready) begin
                sb.push_back(d);
                d++;
            end
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            if (out_valid) check("stream_drain", out_bits, sb.pop_front());
            tick();
            n++;
        end
        check("stream_left", sb.size(), 0);
        check("stream_empty", occupancy, 0);

        // Stall counter, then flush with a beat arriving
        reset = 1'b1; #2 reset = 1'b0;
        tick();
        lat_cfg = 8'd0; out_ready = 1'b0; in_valid = 1'b1; in_bits = 64'd1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("stall_3", stall_count, 3);
        in_valid = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            in_bits = 64'(k);
            tick();
        end
        in_bits = 64'h77; flush = 1'b1;
        #1;
        check("flush_pre_occ",   occupancy, 5);
        check("flush_in_ready",  in_ready,  0);
        check("flush_out_valid", out_valid, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_occ",   occupancy,   0);
        check("flush_stall", stall_count, 7);
        in_valid = 1'b1; in_bits = 64'h88;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("post_flush_valid", out_valid, 1);
        check("post_flush_bits",  out_bits,  64'h88);
        check("post_flush_occ",   occupancy, 1);
        tick();
        check("post_flush_empty", occupancy, 0);

        // Asynchronous reset between clock edges
        out_ready = 1'b0; in_valid = 1'b1; in_bits = 64'h33;
        tick();
        tick();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("areset_occ",   occupancy,   0);
        check("areset_valid", out_valid,   0);
        check("areset_ready", in_ready,    1);
        check("areset_stall", stall_count, 0);
        #2 reset = 1'b0;
        tick();
        in_valid = 1'b1; in_bits = 64'h5A;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("after_reset_valid", out_valid, 1);
        check("after_reset_bits",  out_bits,  64'h5A);
        check("after_reset_occ",   occupancy, 1);
        tick();
        check("after_reset_empty", occupancy, 0);

        // Saturation of a 4-bit stall counter
        sat_in_valid = 1'b1; sat_in_bits = 8'h3C; sat_out_ready = 1'b0;
        tick();
        sat_in_valid = 1'b0;
        repeat (10) tick();
        check("sat_10",   sat_stall_count, 10);
        check("sat_bits", sat_out_bits,    8'h3C);
        repeat (10) tick();
        check("sat_20",   sat_stall_count, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
